// File: rtl/led_flow_seq.sv
// Multi-channel LED sequencer: a prescaler sets the step period, and a pointer walks the LEDs (left/right/ping-pong/all-blink) with a PWM duty window.
// Optional build macro LED_TRAIL_EN: also lights the previous position briefly, which gives a dim trailing LED.
//
// state    | meaning
// ---------+------------------------------------------------
// ST_IDLE  | after reset, waiting for the first en=1
// ST_RUN   | prescaler counting, pointer stepping, LEDs driven
// ST_PAUSE | cnt/pos frozen, LEDs dark, waiting for en=1
module led_flow_seq #(
  parameter int unsigned N_LED       = 8,
  parameter int unsigned STEP_CYCLES = 5_000_000,
  parameter int unsigned ON_CYCLES   = 1_250_000,
  parameter int unsigned CNT_W       = 23,
  parameter int unsigned POS_W       = 3
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             en,
  input  logic [1:0]       mode,
  output logic [N_LED-1:0] LED_out,
  output logic [POS_W-1:0] pos,
  output logic             step_tick
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam logic [1:0]       MODE_LEFT  = 2'b00;
  localparam logic [1:0]       MODE_RIGHT = 2'b01;
  localparam logic [1:0]       MODE_PING  = 2'b10;
  localparam logic [1:0]       MODE_BLINK = 2'b11;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(STEP_CYCLES - 1);
  localparam logic [POS_W-1:0] POS_LAST   = POS_W'(N_LED - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic               dir_q, dir_d;
  logic [1:0]         mode_q, mode_d;
  logic [N_LED-1:0]   led_q, led_d;

  logic               at_last;
  logic               advance;
  logic               boundary;
  logic               lit;
  logic [31:0]        cnt_ext;
  logic [N_LED-1:0]   pos_hot;

`ifdef LED_TRAIL_EN
  localparam int unsigned TRAIL_CYCLES = ON_CYCLES / 4;
  logic [POS_W-1:0]   pos_prev_q, pos_prev_d;
  logic               trail;
  logic [N_LED-1:0]   prev_hot;
`endif

  // A RUN cycle always completes its own step update, even if en falls in it,
  // so a boundary on the last cycle is never lost when pausing.
  always_comb begin
    at_last  = (cnt_q == CNT_LAST);
    advance  = (state_q == ST_RUN) && (en || at_last);
    boundary = advance && at_last;
    cnt_ext  = 32'(cnt_q);
    lit      = (cnt_ext < ON_CYCLES);
    pos_hot  = N_LED'(1) << pos_q;
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = ST_RUN;
          mode_d  = mode;
        end
      end
      ST_RUN: begin
        if (!en) state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (en) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
    if (boundary) mode_d = mode;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (advance) cnt_d = at_last ? '0 : cnt_q + CNT_W'(1);
  end

  always_comb begin
    pos_d = pos_q;
    dir_d = dir_q;
    if (boundary && (N_LED > 1)) begin
      case (mode_q)
        MODE_LEFT: begin
          pos_d = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
          dir_d = 1'b1;
        end
        MODE_RIGHT: begin
          pos_d = (pos_q == '0) ? POS_LAST : pos_q - POS_W'(1);
          dir_d = 1'b0;
        end
        MODE_PING: begin
          // Reverse on the endpoint itself so each end is shown for one step only.
          if (dir_q) begin
            if (pos_q == POS_LAST) begin
              pos_d = POS_LAST - POS_W'(1);
              dir_d = 1'b0;
            end else begin
              pos_d = pos_q + POS_W'(1);
            end
          end else begin
            if (pos_q == '0) begin
              pos_d = POS_W'(1);
              dir_d = 1'b1;
            end else begin
              pos_d = pos_q - POS_W'(1);
            end
          end
        end
        default: pos_d = pos_q;
      endcase
    end
  end

`ifdef LED_TRAIL_EN
  always_comb begin
    trail      = (cnt_ext < TRAIL_CYCLES);
    prev_hot   = N_LED'(1) << pos_prev_q;
    pos_prev_d = boundary ? pos_q : pos_prev_q;
  end
`endif

  always_comb begin
    led_d = '0;
    if ((state_q == ST_RUN) && en) begin
      if (mode_q == MODE_BLINK) begin
        led_d = lit ? '1 : '0;
      end else begin
        if (lit) led_d = pos_hot;
`ifdef LED_TRAIL_EN
        if (trail && (N_LED > 1)) led_d = led_d | prev_hot;
`endif
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pos_q   <= '0;
      dir_q   <= 1'b1;
      mode_q  <= MODE_LEFT;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      led_q   <= led_d;
    end
  end

`ifdef LED_TRAIL_EN
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) pos_prev_q <= '0;
    else       pos_prev_q <= pos_prev_d;
  end
`endif

  assign LED_out   = led_q;
  assign pos       = pos_q;
  assign step_tick = (state_q == ST_RUN) && at_last;

endmodule

// File: tb/tb_led_flow_seq.sv
// Bench for led_flow_seq: directed phases with randomized en/mode, checked every cycle
// against a behavioural model of the step sequence.
module tb_led_flow_seq;
  localparam int N    = 4;
  localparam int STEP = 10;
  localparam int ON   = 4;

  logic       CLK = 1'b0;
  logic       RSTn;
  logic       en;
  logic [1:0] mode;
  logic [3:0] LED_out;
  logic [1:0] pos;
  logic       step_tick;

  int n_cmp = 0;
  int n_bad = 0;

  // model: m_state 0 = idle, 1 = run, 2 = pause
  int m_state, m_cnt, m_pos, m_prev, m_mode, m_led;
  bit m_up;

  always #5 CLK = ~CLK;

  led_flow_seq #(
    .N_LED(N), .STEP_CYCLES(STEP), .ON_CYCLES(ON), .CNT_W(4), .POS_W(2)
  ) dut (
    .CLK(CLK), .RSTn(RSTn), .en(en), .mode(mode),
    .LED_out(LED_out), .pos(pos), .step_tick(step_tick)
  );

  function automatic void model_reset();
    m_state = 0; m_cnt = 0; m_pos = 0; m_prev = 0; m_mode = 0; m_led = 0; m_up = 1'b1;
  endfunction

  // Ping-pong is a walk around a cycle of 2N-2 slots, folded back onto 0..N-1.
  function automatic void step_pointer();
    int per, idx;
    per = 2 * N - 2;
    case (m_mode)
      0: begin m_pos = (m_pos + 1) % N; m_up = 1'b1; end
      1: begin m_pos = (m_pos + N - 1) % N; m_up = 1'b0; end
      2: begin
        idx   = m_up ? m_pos : (per - m_pos) % per;
        idx   = (idx + 1) % per;
        m_pos = (idx < N) ? idx : per - idx;
        m_up  = (idx < N - 1);
      end
      default: ;
    endcase
  endfunction

  function automatic void model_edge();
    int led_n;
    bit last;
    if (!RSTn) begin
      model_reset();
      return;
    end
    led_n = 0;
    last  = (m_cnt == STEP - 1);
    if (m_state == 1 && en) begin
      if (m_cnt < ON) led_n = (m_mode == 3) ? 'hF : (1 << m_pos);
`ifdef LED_TRAIL_EN
      if (m_mode != 3 && m_cnt < ON / 4) led_n = led_n | (1 << m_prev);
`endif
    end
    case (m_state)
      0: if (en) begin m_state = 1; m_mode = int'(mode); end
      1: begin
        if (en || last) begin
          if (last) begin
            m_cnt  = 0;
            m_prev = m_pos;
            step_pointer();
            m_mode = int'(mode);
          end else begin
            m_cnt++;
          end
        end
        if (!en) m_state = 2;
      end
      default: if (en) m_state = 1;
    endcase
    m_led = led_n;
  endfunction

  task automatic check(input string tag);
    logic [3:0] exp_led;
    logic [1:0] exp_pos;
    logic       exp_tick;
    exp_led  = 4'(m_led);
    exp_pos  = 2'(m_pos);
    exp_tick = (m_state == 1) && (m_cnt == STEP - 1);
    n_cmp++;
    assert (LED_out === exp_led) else begin
      n_bad++;
      $error("FAIL %s LED_out observed=%b expected=%b", tag, LED_out, exp_led);
    end
    n_cmp++;
    assert (pos === exp_pos) else begin
      n_bad++;
      $error("FAIL %s pos observed=%0d expected=%0d", tag, pos, exp_pos);
    end
    n_cmp++;
    assert (step_tick === exp_tick) else begin
      n_bad++;
      $error("FAIL %s step_tick observed=%b expected=%b", tag, step_tick, exp_tick);
    end
  endtask

  task automatic cyc(input string tag);
    @(posedge CLK);
    model_edge();
    #1;
    check(tag);
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(tag);
  endtask

  task automatic wait_cnt(input int target, input string tag);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (m_state == 1 && m_cnt == target) begin
        found = 1'b1;
        break;
      end
      cyc(tag);
    end
    n_cmp++;
    assert (found) else begin
      n_bad++;
      $error("FAIL %s wait observed=timeout expected=cnt%0d", tag, target);
    end
  endtask

  initial begin
    RSTn = 1'b0;
    en   = 1'b0;
    mode = 2'b00;
    model_reset();
    #2;
    check("reset_init");
    for (int i = 0; i < 8; i++) begin
      en   = 1'($urandom);
      mode = 2'($urandom);
      cyc("reset_hold");
    end

    // left sweep
    RSTn = 1'b1;
    en   = 1'b1;
    mode = 2'b00;
    run(50, "left");

    // ping-pong
    mode = 2'b10;
    run(70, "pingpong");

    // mid-step mode change left -> right
    mode = 2'b00;
    run(20, "pre_switch");
    wait_cnt(5, "wait_cnt5");
    mode = 2'b01;
    run(30, "mode_switch");

    // pause mid-step and resume
    wait_cnt(3, "wait_cnt3");
    en = 1'b0;
    run(20, "pause");
    en = 1'b1;
    run(20, "resume");

    // en dropping on the step_tick cycle
    wait_cnt(STEP - 1, "wait_tick");
    en = 1'b0;
    run(5, "drop_on_tick");
    en = 1'b1;
    run(15, "after_drop");

    // randomized en/mode
    for (int i = 0; i < 300; i++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom);
      cyc("random");
    end

    // asynchronous reset mid-step
    en   = 1'b1;
    mode = 2'b00;
    run(12, "pre_reset");
    wait_cnt(7, "wait_cnt7");
    RSTn = 1'b0;
    #1;
    model_reset();
    check("async_reset");
    run(3, "reset_hold2");
    RSTn = 1'b1;
    run(30, "restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
